yags_predictor_param: RTL and testbench

Parametrised YAGS direction predictor for the RV32I pipeline's fetch stage. It has:

- a PC-indexed choice PHT;
- taken and not-taken exception caches indexed by PC XOR global history, with partial tags;
- a speculative global history register (GHR) with mispredict recovery;
- saturating lookup and mispredict statistics.

Prediction is combinational in the fetch cycle. Training arrives from execute through a separate update port.

---
 rtl/yags_predictor_param.sv | 130 +++++++++++++
 tb/tb_yags_predictor_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/yags_predictor_param.sv
// YAGS direction predictor: PC-indexed choice PHT plus tagged taken/not-taken
// exception caches indexed by PC^GHR, with a speculative GHR and statistics.
module yags_predictor_param #(
    parameter int PC_W         = 32,
    parameter int GHR_W        = 8,
    parameter int CHOICE_IDX_W = 10,
    parameter int CACHE_IDX_W  = 8,
    parameter int TAG_W        = 6,
    parameter int STAT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [GHR_W-1:0]  upd_ghr,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int NC = 1 << CHOICE_IDX_W;
    localparam int NX = 1 << CACHE_IDX_W;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
    } ent_t;

    logic [1:0]        choice_q [NC];
    ent_t              tc_q     [NX];
    ent_t              ntc_q    [NX];
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic [STAT_W-1:0] lk_q, lk_d, mp_q, mp_d;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        else    return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Lookup side
    logic [CHOICE_IDX_W-1:0] p_ci;
    logic [CACHE_IDX_W-1:0]  p_xi;
    logic [TAG_W-1:0]        p_tag;
    logic                    p_bias, p_hit;
    ent_t                    p_ent;

    assign p_ci   = pred_pc[CHOICE_IDX_W+1:2];
    assign p_xi   = pred_pc[CACHE_IDX_W+1:2] ^ CACHE_IDX_W'(ghr_q);
    assign p_tag  = pred_pc[TAG_W+1:2];
    assign p_bias = choice_q[p_ci][1];
    // Taken-biased branches look for not-taken exceptions and vice versa.
    assign p_ent  = p_bias ? ntc_q[p_xi] : tc_q[p_xi];
    assign p_hit  = p_ent.vld && (p_ent.tag == p_tag);
    assign pred_taken = p_hit ? p_ent.ctr[1] : p_bias;
    assign pred_ghr   = ghr_q;

    // Update side
    logic [CHOICE_IDX_W-1:0] u_ci;
    logic [CACHE_IDX_W-1:0]  u_xi;
    logic [TAG_W-1:0]        u_tag;
    logic                    u_bias, u_hit, u_protect, u_cwe, u_chwe;
    logic [1:0]              u_choice_d;
    ent_t                    u_ent, u_ent_d;

    assign u_ci   = upd_pc[CHOICE_IDX_W+1:2];
    assign u_xi   = upd_pc[CACHE_IDX_W+1:2] ^ CACHE_IDX_W'(upd_ghr);
    assign u_tag  = upd_pc[TAG_W+1:2];
    assign u_bias = choice_q[u_ci][1];
    assign u_ent  = u_bias ? ntc_q[u_xi] : tc_q[u_xi];
    assign u_hit  = u_ent.vld && (u_ent.tag == u_tag);

    always_comb begin
        u_ent_d = u_ent;
        u_cwe   = 1'b0;
        if (u_hit) begin
            u_ent_d.ctr = sat2(u_ent.ctr, upd_taken);
            u_cwe       = upd_valid;
        end else if (upd_taken != u_bias) begin
            u_ent_d.vld = 1'b1;
            u_ent_d.tag = u_tag;
            u_ent_d.ctr = u_bias ? 2'b01 : 2'b10;
            u_cwe       = upd_valid;
        end
        // An exception entry already got this one right; keep the bias intact.
        u_protect  = u_hit && (u_ent.ctr[1] == upd_taken) && (u_bias != upd_taken);
        u_chwe     = upd_valid && !u_protect;
        u_choice_d = sat2(choice_q[u_ci], upd_taken);
    end

    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid && upd_mispredict) ghr_d = {upd_ghr[GHR_W-2:0], upd_taken};
        else if (pred_valid)             ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
        lk_d = (pred_valid && (lk_q != '1)) ? lk_q + STAT_W'(1) : lk_q;
        mp_d = (upd_valid && upd_mispredict && (mp_q != '1)) ? mp_q + STAT_W'(1) : mp_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) choice_q[i] <= 2'b01;
            for (int i = 0; i < NX; i++) begin
                tc_q[i]  <= '0;
                ntc_q[i] <= '0;
            end
            ghr_q <= '0;
            lk_q  <= '0;
            mp_q  <= '0;
        end else begin
            if (u_chwe) choice_q[u_ci] <= u_choice_d;
            if (u_cwe) begin
                if (u_bias) ntc_q[u_xi] <= u_ent_d;
                else        tc_q[u_xi]  <= u_ent_d;
            end
            ghr_q <= ghr_d;
            lk_q  <= lk_d;
            mp_q  <= mp_d;
        end
    end

    assign stat_lookups     = lk_q;
    assign stat_mispredicts = mp_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, upd_pc};
endmodule

// File: tb/tb_yags_predictor_param.sv
// Directed bench for yags_predictor_param: reset, bias training, exception
// allocation, choice protection, GHR recovery and saturating statistics.
module tb_yags_predictor_param;
    localparam int PC_W = 32, GHR_W = 8, STAT_W = 4;

    logic              clk = 1'b0, reset = 1'b0;
    logic              pred_valid, pred_taken, upd_valid, upd_taken, upd_mispredict;
    logic [PC_W-1:0]   pred_pc, upd_pc;
    logic [GHR_W-1:0]  pred_ghr, upd_ghr;
    logic [STAT_W-1:0] stat_lookups, stat_mispredicts;
    int n_cmp = 0, n_bad = 0;

    yags_predictor_param #(.PC_W(PC_W), .GHR_W(GHR_W), .CHOICE_IDX_W(10),
                           .CACHE_IDX_W(8), .TAG_W(6), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        upd_taken = 1'b0; upd_pc = '0; upd_ghr = '0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] g, input logic t, input logic m);
        upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = t; upd_mispredict = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        pred_pc = 32'h100;
        tick(); tick();
        reset = 1'b1;
        tick();

        // 1. traffic, then an asynchronous reset in mid-cycle
        pred_valid = 1'b1;
        upd(32'h100, 8'h00, 1'b1, 1'b1);
        tick(); tick();
        idle();
        #1;
        chk("pre_rst_taken", pred_taken, 1);
        chk("pre_rst_lookups", stat_lookups, 2);
        chk("pre_rst_mispred", stat_mispredicts, 2);
        chk("pre_rst_ghr", pred_ghr, 8'h01);
        #2 reset = 1'b0;
        #1;
        chk("rst_taken", pred_taken, 0);
        chk("rst_ghr", pred_ghr, 0);
        chk("rst_lookups", stat_lookups, 0);
        chk("rst_mispred", stat_mispredicts, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("post_rst_taken", pred_taken, 0);
        chk("post_rst_ghr", pred_ghr, 0);

        // 2. bias training; lookup during the write sees old contents
        upd(32'h100, 8'h00, 1'b1, 1'b0);
        #1 chk("no_bypass", pred_taken, 0);
        tick();
        chk("bias_after_1", pred_taken, 1);
        tick();
        idle();
        chk("bias_after_2", pred_taken, 1);
        upd(32'h200, 8'h2A, 1'b0, 1'b1);
        tick();
        idle();
        chk("recover_ghr_54", pred_ghr, 8'h54);
        chk("bias_other_ghr", pred_taken, 1);
        chk("mispred_1", stat_mispredicts, 1);

        // 3. NT exception allocation at xi 0x45
        upd(32'h100, 8'h05, 1'b0, 1'b0);
        tick();
        upd(32'h300, 8'h02, 1'b1, 1'b1);
        tick();
        idle();
        chk("ghr_05", pred_ghr, 8'h05);
        chk("exc_hit_taken", pred_taken, 0);
        upd(32'h400, 8'h00, 1'b0, 1'b1);
        tick();
        idle();
        chk("ghr_00", pred_ghr, 8'h00);
        chk("exc_miss_taken", pred_taken, 1);

        // 4. choice protection, then confirm the cache counter went 01->00
        upd(32'h100, 8'h05, 1'b0, 1'b0);
        tick();
        idle();
        chk("choice_protected", pred_taken, 1);
        upd(32'h100, 8'h05, 1'b1, 1'b0);
        tick();
        upd(32'h400, 8'h02, 1'b1, 1'b1);
        tick();
        idle();
        chk("ghr_05_again", pred_ghr, 8'h05);
        chk("cache_ctr_01", pred_taken, 0);
        upd_pc = 32'h100; upd_ghr = 8'h05; upd_taken = 1'b1; upd_mispredict = 1'b1;
        upd_valid = 1'b0;
        tick();
        idle();
        chk("novalid_ghr", pred_ghr, 8'h05);
        chk("novalid_tables", pred_taken, 0);

        // 5. speculative GHR and recovery priority
        reset = 1'b0;
        tick();
        reset = 1'b1;
        upd(32'h100, 8'h00, 1'b1, 1'b0);
        tick(); tick();
        idle();
        pred_valid = 1'b1;
        pred_pc = 32'h100;
        chk("spec_first_taken", pred_taken, 1);
        tick(); tick(); tick();
        chk("spec_ghr_07", pred_ghr, 8'h07);
        upd(32'h500, 8'h0A, 1'b1, 1'b1);
        tick();
        idle();
        chk("recover_prio_15", pred_ghr, 8'h15);
        chk("lookups_4", stat_lookups, 4);

        // 6. statistics saturation at STAT_W = 4
        reset = 1'b0;
        tick();
        reset = 1'b1;
        pred_valid = 1'b1;
        repeat (14) tick();
        chk("lookups_14", stat_lookups, 14);
        repeat (6) tick();
        pred_valid = 1'b0;
        chk("lookups_sat", stat_lookups, 15);
        upd(32'h100, 8'h00, 1'b0, 1'b1);
        repeat (3) tick();
        idle();
        chk("mispred_3", stat_mispredicts, 3);
        chk("lookups_hold", stat_lookups, 15);
        upd(32'h100, 8'h00, 1'b0, 1'b1);
        repeat (15) tick();
        idle();
        chk("mispred_sat", stat_mispredicts, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
